// File: rtl/disp_pkg.sv
// Shared display definitions: digit-slot index and fixed segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

  typedef enum logic [1:0] {
    DIG_U = 2'd0,
    DIG_T = 2'd1,
    DIG_H = 2'd2
  } dig_idx_t;

  localparam logic [6:0] SEG_DASH  = 7'b100_0000;
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

endpackage

// File: rtl/ssd_scan_mux_ssd.sv
// BCD to 7-segment glyph decoder, segments {g,f,e,d,c,b,a} active-high.
module ssd_scan_mux_ssd
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = 7'h3f;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5b;
      4'd3: seg = 7'h4f;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6d;
      4'd6: seg = 7'h7d;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7f;
      4'd9: seg = 7'h6f;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Three-digit multiplexed 7-segment driver with frame-synchronous update,
// leading-zero blanking and anode dead time at the start of every digit slot.
module ssd_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned DEAD_CYC    = 16,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [3:0] dig_u,
  input  logic [3:0] dig_t,
  input  logic [3:0] dig_h,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int unsigned CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [2:0]  AN_OFF = AN_ACT_LOW ? 3'b111 : 3'b000;

  logic [CW-1:0] div_q;
  dig_idx_t      idx_q, idx_d;
  logic [11:0]   pend_q, disp_q;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          tick_q;

  logic          slot_end, wrap;
  logic [11:0]   new_val;
  logic [3:0]    cur;
  logic [6:0]    glyph;
  logic          blank;
  logic [2:0]    an_on;

  assign slot_end = (div_q == CW'(REFRESH_DIV - 1));
  assign wrap     = slot_end && (idx_q == DIG_H);
  assign new_val  = {dig_h, dig_t, dig_u};

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      unique case (idx_q)
        DIG_U:   idx_d = DIG_T;
        DIG_T:   idx_d = DIG_H;
        DIG_H:   idx_d = DIG_U;
        default: idx_d = DIG_U;
      endcase
    end
  end

  always_comb begin
    cur = disp_q[3:0];
    unique case (idx_q)
      DIG_U:   cur = disp_q[3:0];
      DIG_T:   cur = disp_q[7:4];
      DIG_H:   cur = disp_q[11:8];
      default: cur = disp_q[3:0];
    endcase
  end

  ssd_scan_mux_ssd u_ssd (
    .bcd (cur),
    .seg (glyph)
  );

  // Blank/dash override sits after the decoder so the ssd block stays generic.
  always_comb begin
    blank = BLANK_LZ &&
            (((idx_q == DIG_H) && (disp_q[11:8] == 4'd0)) ||
             ((idx_q == DIG_T) && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0)));
    if (blank) begin
      seg_d = SEG_BLANK;
    end else if (cur > 4'd9) begin
      seg_d = SEG_DASH;
    end else begin
      seg_d = glyph;
    end

    an_on = 3'b001 << idx_q;
    if (32'(div_q) < DEAD_CYC) begin
      an_d = AN_OFF;
    end else begin
      an_d = AN_ACT_LOW ? ~an_on : an_on;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= DIG_U;
      pend_q <= '0;
      disp_q <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= AN_OFF;
      tick_q <= 1'b0;
    end else begin
      div_q  <= slot_end ? '0 : div_q + CW'(1);
      idx_q  <= idx_d;
      if (upd) pend_q <= new_val;
      // A strobe on the wrap cycle bypasses pend so it lands in the coming frame.
      if (wrap) disp_q <= upd ? new_val : pend_q;
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= wrap;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed scoreboard bench: two instances (leading-zero blanking on/off) share all stimulus.
module tb_ssd_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd;
  logic [3:0] dig_u, dig_t, dig_h;
  logic [6:0] seg1, seg0;
  logic [2:0] an1, an0;
  logic       ft1, ft0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] s1;
    logic [6:0] s0;
  } slot_exp_t;

  slot_exp_t sb[$];

  always #5 clk = ~clk;

  ssd_scan_mux #(
    .REFRESH_DIV (8),
    .DEAD_CYC    (2),
    .BLANK_LZ    (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd),
    .dig_u      (dig_u),
    .dig_t      (dig_t),
    .dig_h      (dig_h),
    .seg        (seg1),
    .an         (an1),
    .frame_tick (ft1)
  );

  ssd_scan_mux #(
    .REFRESH_DIV (8),
    .DEAD_CYC    (2),
    .BLANK_LZ    (1'b0),
    .AN_ACT_LOW  (1'b1)
  ) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd),
    .dig_u      (dig_u),
    .dig_t      (dig_t),
    .dig_h      (dig_h),
    .seg        (seg0),
    .an         (an0),
    .frame_tick (ft0)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3f;
      4'd1: return 7'h06;
      4'd2: return 7'h5b;
      4'd3: return 7'h4f;
      4'd4: return 7'h66;
      4'd5: return 7'h6d;
      4'd6: return 7'h7d;
      4'd7: return 7'h07;
      4'd8: return 7'h7f;
      4'd9: return 7'h6f;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    slot_exp_t e;
    e.s0 = glyph(u); e.s1 = glyph(u);
    sb.push_back(e);
    e.s0 = glyph(t); e.s1 = (h == 4'd0 && t == 4'd0) ? 7'h00 : glyph(t);
    sb.push_back(e);
    e.s0 = glyph(h); e.s1 = (h == 4'd0) ? 7'h00 : glyph(h);
    sb.push_back(e);
  endtask

  task automatic strobe(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    dig_h = h; dig_t = t; dig_u = u; upd = 1'b1;
    push_frame(h, t, u);
    @(negedge clk);
    upd = 1'b0;
  endtask

  // k counts clock edges after the wrap edge; k==24 is the next wrap.
  task automatic check_frame(input bit nosync, input int upd_at, input logic [11:0] nv);
    slot_exp_t  e;
    logic [2:0] exp_an;
    int         n, pos, slot;
    e.s0 = 7'h00; e.s1 = 7'h00;
    if (!nosync && !ft1) begin
      n = 0;
      while (!ft1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("frame_sync", {6'd0, ft1}, 7'd1);
    end
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      upd  = 1'b0;
      pos  = (k - 1) % 8;
      slot = (k - 1) / 8;
      if (pos == 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL scoreboard_empty observed=0 expected=3");
        end else begin
          e = sb.pop_front();
        end
      end
      exp_an = (pos < 2) ? 3'b111 : ~(3'b001 << slot);
      chk("an_lz1", {4'd0, an1}, {4'd0, exp_an});
      chk("an_lz0", {4'd0, an0}, {4'd0, exp_an});
      chk("seg_lz1", seg1, e.s1);
      chk("seg_lz0", seg0, e.s0);
      chk("frame_tick", {5'd0, ft1, ft0}, (k == 24) ? 7'd3 : 7'd0);
      if (k == upd_at) begin
        {dig_h, dig_t, dig_u} = nv;
        upd = 1'b1;
        push_frame(nv[11:8], nv[7:4], nv[3:0]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; upd = 1'b0; dig_u = 4'd0; dig_t = 4'd0; dig_h = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_an", {4'd0, an1}, 7'h07);
    chk("rst_seg", seg1, 7'h00);
    chk("rst_tick", {6'd0, ft1}, 7'd0);
    push_frame(4'd0, 4'd0, 4'd0);
    rst_n = 1'b1;
    check_frame(1'b1, 0, 12'h000);

    // 225, two frames
    strobe(4'd2, 4'd2, 4'd5);
    check_frame(1'b0, 0, 12'h000);
    push_frame(4'd2, 4'd2, 4'd5);
    check_frame(1'b0, 0, 12'h000);

    // leading zeros, zero value, dash digit
    strobe(4'd0, 4'd0, 4'd7);
    check_frame(1'b0, 0, 12'h000);
    strobe(4'd0, 4'd0, 4'd0);
    check_frame(1'b0, 0, 12'h000);
    strobe(4'd0, 4'hc, 4'd0);
    check_frame(1'b0, 0, 12'h000);

    // tear-free update: mid-T-slot strobe, then strobe on the wrap cycle
    strobe(4'd1, 4'd4, 4'd4);
    check_frame(1'b0, 0, 12'h000);
    push_frame(4'd1, 4'd4, 4'd4);
    check_frame(1'b0, 12, 12'h225);
    check_frame(1'b0, 23, 12'h007);
    check_frame(1'b0, 0, 12'h000);

    // asynchronous reset mid-H-slot
    strobe(4'd3, 4'd2, 4'd1);
    check_frame(1'b0, 0, 12'h000);
    repeat (20) @(negedge clk);
    chk("pre_rst_an", {4'd0, an1}, 7'h03);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", {1'b0, an1, an0}, 7'h3f);
    chk("async_rst_seg", seg1, 7'h00);
    chk("async_rst_seg0", seg0, 7'h00);
    chk("async_rst_tick", {5'd0, ft1, ft0}, 7'd0);
    repeat (2) @(negedge clk);
    push_frame(4'd0, 4'd0, 4'd0);
    rst_n = 1'b1;
    check_frame(1'b1, 0, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
